// File: rtl/stack_req_arbiter.sv
// Two-requester round-robin front end for a shared stack datapath.
// Tracks stack occupancy and rejects ops that would overflow or underflow before issuing them.
module stack_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int LAT        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_vld,
    input  logic [1:0]                    req0_op,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    output logic                          req0_rdy,
    output logic                          rsp0_vld,
    output logic                          rsp0_err,
    output logic [DATA_WIDTH-1:0]         rsp0_data,
    input  logic                          req1_vld,
    input  logic [1:0]                    req1_op,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    output logic                          req1_rdy,
    output logic                          rsp1_vld,
    output logic                          rsp1_err,
    output logic [DATA_WIDTH-1:0]         rsp1_data,
    output logic                          stk_en,
    output logic [1:0]                    stk_ctl,
    output logic [DATA_WIDTH-1:0]         stk_din,
    input  logic [DATA_WIDTH-1:0]         stk_dout,
    output logic [$clog2(DEPTH+1)-1:0]    o_occ,
    output logic                          o_busy
);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int HALF_W = DATA_WIDTH / 2;

    localparam logic [1:0] OP_POP        = 2'b00;
    localparam logic [1:0] OP_PUSH_H     = 2'b01;
    localparam logic [1:0] OP_PUSH_W     = 2'b10;
    localparam logic [1:0] OP_PUSH_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t          state_r;
    logic            rr_ptr_r;
    logic            id_r;
    logic [1:0]      op_r;
    logic [2:0]      cnt_r;
    logic            gnt_vld_s;
    logic            gnt_id_s;
    logic [1:0]      gnt_op_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic [DATA_WIDTH-1:0] pop_word_s;

    function automatic logic op_legal(input logic [1:0] op, input logic [OCC_W-1:0] occ);
        int occ_i;
        occ_i = int'(occ);
        case (op)
            OP_POP:               op_legal = (occ_i >= 1);
            OP_PUSH_H, OP_PUSH_W: op_legal = (occ_i <= DEPTH - 1);
            OP_PUSH_SPLIT:        op_legal = (occ_i <= DEPTH - 2);
            default:              op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] form_operand(input logic [1:0] op,
                                                           input logic [DATA_WIDTH-1:0] data);
        case (op)
            OP_PUSH_H:                form_operand = {{(DATA_WIDTH-HALF_W){1'b0}}, data[HALF_W-1:0]};
            OP_PUSH_W, OP_PUSH_SPLIT: form_operand = data;
            default:                  form_operand = {DATA_WIDTH{1'b0}};
        endcase
    endfunction

    function automatic logic [OCC_W-1:0] occ_after(input logic [1:0] op, input logic [OCC_W-1:0] occ);
        case (op)
            OP_POP:               occ_after = occ - OCC_W'(1);
            OP_PUSH_H, OP_PUSH_W: occ_after = occ + OCC_W'(1);
            OP_PUSH_SPLIT:        occ_after = occ + OCC_W'(2);
            default:              occ_after = occ;
        endcase
    endfunction

    // Grant selection: a lone requester wins, contention goes to rr_ptr_r.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
        if (state_r == IDLE) begin
            if (req0_vld && req1_vld) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = rr_ptr_r;
            end else if (req0_vld) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b0;
            end else if (req1_vld) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b1;
            end else begin
                gnt_vld_s = 1'b0;
            end
        end else begin
            gnt_vld_s = 1'b0;
        end
    end

    assign gnt_op_s   = gnt_id_s ? req1_op : req0_op;
    assign gnt_data_s = gnt_id_s ? req1_data : req0_data;
    assign req0_rdy   = gnt_vld_s & ~gnt_id_s;
    assign req1_rdy   = gnt_vld_s & gnt_id_s;
    assign pop_word_s = (op_r == OP_POP) ? stk_dout : {DATA_WIDTH{1'b0}};

    // Op sequencer: grant, issue strobe, settle countdown, one-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= 1'b0;
            id_r      <= 1'b0;
            op_r      <= 2'b00;
            cnt_r     <= 3'd0;
            o_occ     <= {OCC_W{1'b0}};
            o_busy    <= 1'b0;
            stk_en    <= 1'b0;
            stk_ctl   <= 2'b00;
            stk_din   <= {DATA_WIDTH{1'b0}};
            rsp0_vld  <= 1'b0;
            rsp0_err  <= 1'b0;
            rsp0_data <= {DATA_WIDTH{1'b0}};
            rsp1_vld  <= 1'b0;
            rsp1_err  <= 1'b0;
            rsp1_data <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_vld_s) begin
                        id_r     <= gnt_id_s;
                        op_r     <= gnt_op_s;
                        rr_ptr_r <= ~gnt_id_s;
                        o_busy   <= 1'b1;
                        if (op_legal(gnt_op_s, o_occ)) begin
                            stk_en  <= 1'b1;
                            stk_ctl <= gnt_op_s;
                            stk_din <= form_operand(gnt_op_s, gnt_data_s);
                            state_r <= ISSUE;
                        end else begin
                            // Rejected ops skip the stack entirely and answer next cycle.
                            if (gnt_id_s) begin
                                rsp1_vld  <= 1'b1;
                                rsp1_err  <= 1'b1;
                                rsp1_data <= {DATA_WIDTH{1'b0}};
                            end else begin
                                rsp0_vld  <= 1'b1;
                                rsp0_err  <= 1'b1;
                                rsp0_data <= {DATA_WIDTH{1'b0}};
                            end
                            state_r <= RESP;
                        end
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    stk_en  <= 1'b0;
                    stk_ctl <= 2'b00;
                    stk_din <= {DATA_WIDTH{1'b0}};
                    o_occ   <= occ_after(op_r, o_occ);
                    cnt_r   <= 3'(LAT - 1);
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (cnt_r == 3'd0) begin
                        if (id_r) begin
                            rsp1_vld  <= 1'b1;
                            rsp1_err  <= 1'b0;
                            rsp1_data <= pop_word_s;
                        end else begin
                            rsp0_vld  <= 1'b1;
                            rsp0_err  <= 1'b0;
                            rsp0_data <= pop_word_s;
                        end
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    rsp0_vld  <= 1'b0;
                    rsp0_err  <= 1'b0;
                    rsp0_data <= {DATA_WIDTH{1'b0}};
                    rsp1_vld  <= 1'b0;
                    rsp1_err  <= 1'b0;
                    rsp1_data <= {DATA_WIDTH{1'b0}};
                    o_busy    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_req_arbiter.sv
// Randomized bench for stack_req_arbiter: a transaction-level model (queue-based stack,
// grant timeline) predicts every handshake, strobe and response cycle by cycle.
module tb_stack_req_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam int LAT   = 2;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int NC    = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [1:0] req0_op, req1_op, stk_ctl;
    logic [DW-1:0] req0_data, req1_data, rsp0_data, rsp1_data, stk_din, stk_dout;
    logic rsp0_vld, rsp0_err, rsp1_vld, rsp1_err, stk_en, o_busy;
    logic [OW-1:0] o_occ;

    always #5 clk = ~clk;

    stack_req_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_op(req0_op), .req0_data(req0_data), .req0_rdy(req0_rdy),
        .rsp0_vld(rsp0_vld), .rsp0_err(rsp0_err), .rsp0_data(rsp0_data),
        .req1_vld(req1_vld), .req1_op(req1_op), .req1_data(req1_data), .req1_rdy(req1_rdy),
        .rsp1_vld(rsp1_vld), .rsp1_err(rsp1_err), .rsp1_data(rsp1_data),
        .stk_en(stk_en), .stk_ctl(stk_ctl), .stk_din(stk_din), .stk_dout(stk_dout),
        .o_occ(o_occ), .o_busy(o_busy)
    );

    int vec_cnt = 0;
    int miss_cnt = 0;
    int cyc = 0;
    int free_at = 0;
    int last_g = -1;
    bit rr = 1'b0;
    bit gen_en = 1'b0;
    logic [DW-1:0] stk_q[$];
    bit pend[2];
    logic [1:0] pop_op[2];
    logic [DW-1:0] pdat[2];

    bit e_en[NC];
    logic [1:0] e_ctl[NC];
    logic [DW-1:0] e_din[NC];
    bit e_rv[NC];
    bit e_rid[NC];
    bit e_rerr[NC];
    logic [DW-1:0] e_rdat[NC];
    int e_rocc[NC];
    bit d_ok[NC];
    logic [DW-1:0] d_val[NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < NC; i++) begin
            e_en[i] = 0; e_ctl[i] = 2'b00; e_din[i] = '0;
            e_rv[i] = 0; e_rid[i] = 0; e_rerr[i] = 0; e_rdat[i] = '0; e_rocc[i] = 0;
            d_ok[i] = 0; d_val[i] = '0;
        end
    endtask

    // Reference: decide legality from stack size, schedule strobe, stack data and response.
    task automatic model_grant(input bit id);
        logic [1:0] op;
        logic [DW-1:0] d, v;
        bit ok;
        int c, sz;
        c = cyc; op = pop_op[id]; d = pdat[id]; sz = stk_q.size();
        pend[id] = 0; rr = !id; last_g = c;
        case (op)
            2'b00:        ok = (sz >= 1);
            2'b01, 2'b10: ok = (sz + 1 <= DEPTH);
            default:      ok = (sz + 2 <= DEPTH);
        endcase
        v = '0;
        if (!ok) begin
            e_rv[c+1] = 1; e_rid[c+1] = id; e_rerr[c+1] = 1; e_rdat[c+1] = '0;
            e_rocc[c+1] = sz;
            free_at = c + 2;
        end else begin
            e_en[c+1] = 1; e_ctl[c+1] = op;
            e_din[c+1] = (op == 2'b00) ? 32'h0 : ((op == 2'b01) ? (d & 32'h0000FFFF) : d);
            case (op)
                2'b00: begin
                    v = stk_q.pop_back();
                    d_ok[c+1+LAT] = 1; d_val[c+1+LAT] = v;
                end
                2'b01: stk_q.push_back(d & 32'h0000FFFF);
                2'b10: stk_q.push_back(d);
                default: begin
                    stk_q.push_back(d & 32'h0000FFFF);
                    stk_q.push_back(d >> 16);
                end
            endcase
            e_rv[c+LAT+2] = 1; e_rid[c+LAT+2] = id; e_rerr[c+LAT+2] = 0;
            e_rdat[c+LAT+2] = v; e_rocc[c+LAT+2] = stk_q.size();
            free_at = c + LAT + 3;
        end
    endtask

    task automatic step();
        bit gv, gid;
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (gen_en && !pend[i] && $urandom_range(0, 2) == 0) begin
                pend[i] = 1; pop_op[i] = 2'($urandom_range(0, 3)); pdat[i] = $urandom;
            end
        end
        req0_vld = pend[0]; req0_op = pop_op[0]; req0_data = pdat[0];
        req1_vld = pend[1]; req1_op = pop_op[1]; req1_data = pdat[1];
        stk_dout = d_ok[cyc] ? d_val[cyc] : $urandom;
        #1;
        gv  = (cyc >= free_at) && (pend[0] || pend[1]);
        gid = (pend[0] && pend[1]) ? rr : pend[1];
        chk("rdy0", req0_rdy, gv && !gid);
        chk("rdy1", req1_rdy, gv && gid);
        chk("busy", o_busy, (cyc > last_g) && (cyc < free_at));
        chk("stk_en", stk_en, e_en[cyc]);
        chk("stk_ctl", stk_ctl, e_ctl[cyc]);
        chk("stk_din", stk_din, e_din[cyc]);
        chk("rsp0_vld", rsp0_vld, e_rv[cyc] && !e_rid[cyc]);
        chk("rsp1_vld", rsp1_vld, e_rv[cyc] && e_rid[cyc]);
        if (e_rv[cyc]) begin
            chk("rsp_err", e_rid[cyc] ? rsp1_err : rsp0_err, e_rerr[cyc]);
            chk("rsp_data", e_rid[cyc] ? rsp1_data : rsp0_data, e_rdat[cyc]);
            chk("occ", o_occ, e_rocc[cyc]);
        end
        if (gv) model_grant(gid);
    endtask

    task automatic reset_mid_wait();
        gen_en = 0; pend[0] = 0; pend[1] = 0;
        while (cyc < free_at) step();
        pend[0] = 1; pdat[0] = 32'h0BADF00D;
        pop_op[0] = (stk_q.size() == DEPTH) ? 2'b00 : 2'b10;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stk_en", stk_en, 1'b0);
        chk("arst_stk_ctl", stk_ctl, 2'b00);
        chk("arst_stk_din", stk_din, 32'h0);
        chk("arst_rsp0", {rsp0_vld, rsp0_err, rsp1_vld, rsp1_err}, 4'h0);
        chk("arst_rdata", rsp0_data | rsp1_data, 32'h0);
        chk("arst_occ", o_occ, 0);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_rdy", {req0_rdy, req1_rdy}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stk_q.delete(); rr = 0; clear_sched();
        free_at = 0; last_g = -1; pend[0] = 0; pend[1] = 0; gen_en = 1;
    endtask

    initial begin
        req0_vld = 0; req1_vld = 0; req0_op = 2'b00; req1_op = 2'b00;
        req0_data = '0; req1_data = '0; stk_dout = '0;
        pend[0] = 0; pend[1] = 0;
        pop_op[0] = 2'b00; pop_op[1] = 2'b00; pdat[0] = '0; pdat[1] = '0;
        clear_sched();
        #12;
        chk("rst_stk_en", stk_en, 1'b0);
        chk("rst_stk_din", stk_din, 32'h0);
        chk("rst_rsp", {rsp0_vld, rsp1_vld, rsp0_err, rsp1_err}, 4'h0);
        chk("rst_occ", o_occ, 0);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Both requesters pending at once right after reset: req0 must win first.
        pend[0] = 1; pop_op[0] = 2'b10; pdat[0] = 32'hDEADBEEF;
        pend[1] = 1; pop_op[1] = 2'b01; pdat[1] = 32'hABCD1234;
        gen_en = 1;
        repeat (1200) step();
        reset_mid_wait();
        repeat (400) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
